// File: rtl/shift_iter_unit_pkg.sv
// Shared types for the multi-cycle shift unit: FSM states and shift op encoding.
package shift_iter_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2
  } op_e;

  // Left takes priority over the logical/arithmetic selector.
  function automatic op_e decode_op(input logic is_left, input logic is_logical);
    if (is_left)         return OP_SLL;
    else if (is_logical) return OP_SRL;
    else                 return OP_SRA;
  endfunction

endpackage

// File: rtl/shift_iter_unit_step.sv
// Combinational single-step shifter: shifts by k (0..STEP) in the selected op.
module shift_step
  import shift_iter_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int KW    = 3
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [KW-1:0]    k_i,
  input  op_e              op_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] fill_mask;

  always_comb begin
    ones      = '1;
    // Arithmetic fill comes from the originally captured sign bit, not data_i.
    fill_mask = fill_i ? ~(ones >> k_i) : '0;
    data_o    = data_i;
    case (op_i)
      OP_SLL:  data_o = data_i << k_i;
      OP_SRL:  data_o = data_i >> k_i;
      OP_SRA:  data_o = (data_i >> k_i) | fill_mask;
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_iter_unit.sv
// Multi-cycle shift unit: accepts one op, shifts up to STEP bits per cycle,
// returns the result over a valid/ready response channel.
module shift_iter_unit
  import shift_iter_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_is_left,
  input  logic             in_is_logical,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int             KW       = $clog2(STEP + 1);
  localparam logic [SHW-1:0] STEP_AMT = SHW'(STEP);

  state_e           state_q, state_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  op_e              op_q, op_d;
  logic             fill_q, fill_d;

  logic [KW-1:0]    k;
  logic [SHW-1:0]   rem_next;
  logic [WIDTH-1:0] step_data;
  logic             accept;

  shift_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .data_i (data_q),
    .k_i    (k),
    .op_i   (op_q),
    .fill_i (fill_q),
    .data_o (step_data)
  );

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    k          = KW'((rem_q < STEP_AMT) ? rem_q : STEP_AMT);
    rem_next   = rem_q - SHW'(k);
    state_d    = state_q;
    rem_d      = rem_q;
    data_d     = data_q;
    out_data_d = out_data_q;
    op_d       = op_q;
    fill_d     = fill_q;

    if (flush) begin
      state_d = S_IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            data_d = in_data;
            op_d   = decode_op(in_is_left, in_is_logical);
            fill_d = in_data[WIDTH-1];
            rem_d  = in_shamt;
            if (in_shamt == '0) begin
              out_data_d = in_data;
              state_d    = S_DONE;
            end else begin
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          data_d = step_data;
          rem_d  = rem_next;
          // Result register is loaded only on entry to DONE so it holds while busy.
          if (rem_next == '0) begin
            out_data_d = step_data;
            state_d    = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      data_q     <= '0;
      out_data_q <= '0;
      op_q       <= OP_SLL;
      fill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      data_q     <= data_d;
      out_data_q <= out_data_d;
      op_q       <= op_d;
      fill_q     <= fill_d;
    end
  end

endmodule

// File: tb/tb_shift_iter_unit.sv
// Directed self-checking bench for shift_iter_unit (WIDTH=32, STEP=4).
module tb_shift_iter_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        in_is_left;
  logic        in_is_logical;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  shift_iter_unit #(
    .WIDTH (32),
    .STEP  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_shamt      (in_shamt),
    .in_is_left    (in_is_left),
    .in_is_logical (in_is_logical),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, wait (bounded) for the result, check latency/data, then drain it.
  task automatic run_op(input logic [31:0] d, input logic [4:0] sh, input logic left,
                        input logic logical, input logic [31:0] exp, input int exp_lat,
                        input string tag);
    int lat;
    in_data       = d;
    in_shamt      = sh;
    in_is_left    = left;
    in_is_logical = logical;
    in_valid      = 1'b1;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " data"}, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " drained"}, 32'(out_valid), 32'd0);
    check({tag, " ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] d;
    logic [31:0] exp;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0;
    in_is_left = 1'b0; in_is_logical = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", out_data, 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst in_ready", 32'(in_ready), 32'd1);

    // Directed cases from the plan
    run_op(32'h0000_0001, 5'd31, 1'b1, 1'b0, 32'h8000_0000, 9, "sll31");
    run_op(32'h8000_0000, 5'd4,  1'b0, 1'b0, 32'hF800_0000, 2, "sra4");
    run_op(32'h8000_0000, 5'd4,  1'b0, 1'b1, 32'h0800_0000, 2, "srl4");
    run_op(32'hDEAD_BEEF, 5'd0,  1'b1, 1'b0, 32'hDEAD_BEEF, 1, "sll0");
    run_op(32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 32'hDEAD_BEEF, 1, "sra0");
    run_op(32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'hFFFF_FFFF, 9, "sra31");
    run_op(32'h8421_0000, 5'd5,  1'b0, 1'b0, 32'hFC21_0800, 3, "sra5");
    run_op(32'h0000_00F0, 5'd3,  1'b1, 1'b1, 32'h0000_0780, 2, "sll3_left_prio");

    // Backpressure: result held stable, new request refused
    in_data = 32'h8000_0000; in_shamt = 5'd4; in_is_left = 1'b0; in_is_logical = 1'b0;
    in_valid = 1'b1;
    tick();
    in_data = 32'h1234_5678; in_shamt = 5'd0;
    tick();
    check("bp valid0", 32'(out_valid), 32'd1);
    held = out_data;
    check("bp data0", held, 32'hF800_0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp valid", 32'(out_valid), 32'd1);
      check("bp stable", out_data, 32'hF800_0000);
      check("bp in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp release ready", 32'(in_ready), 32'd1);
    check("bp release valid", 32'(out_valid), 32'd0);
    check("bp out_data held", out_data, 32'hF800_0000);

    // Flush in second BUSY cycle with a simultaneous request
    in_data = 32'hFFFF_FFFF; in_shamt = 5'd20; in_is_left = 1'b0; in_is_logical = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h5555_5555; in_shamt = 5'd0;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) tick();
    check("flush no result", 32'(out_valid), 32'd0);
    check("flush out_data held", out_data, 32'hF800_0000);
    run_op(32'h0000_00F0, 5'd4, 1'b0, 1'b1, 32'h0000_000F, 2, "post_flush_srl");

    // Flush in IDLE while a shamt=0 request is presented: nothing captured
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hCAFE_0000; in_shamt = 5'd0;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("idle_flush no capture", 32'(out_valid), 32'd0);

    // Flush while DONE and stalled discards the result
    in_data = 32'h0000_0003; in_shamt = 5'd1; in_is_left = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("done_flush pre", 32'(out_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("done_flush valid", 32'(out_valid), 32'd0);
    check("done_flush ready", 32'(in_ready), 32'd1);

    // Reset mid-operation
    in_data = 32'h0000_0001; in_shamt = 5'd31; in_is_left = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    check("midrst in_ready", 32'(in_ready), 32'd0);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst out_data", out_data, 32'h0);
    rst = 1'b0; flush = 1'b0;
    #1;
    check("midrst ready after", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) tick();
    check("midrst no result", 32'(out_valid), 32'd0);

    // Sweep every op and shift amount
    for (int op = 0; op < 3; op++) begin
      for (int sh = 0; sh < 32; sh++) begin
        d = 32'h9A5C_3E71 ^ (32'(sh) * 32'h0101_0101);
        if (op == 0)      exp = d << sh;
        else if (op == 1) exp = d >> sh;
        else              exp = $unsigned($signed(d) >>> sh);
        run_op(d, 5'(sh), (op == 0), (op == 1), exp, 1 + (sh + 3) / 4, "sweep");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
